ram_port_arbiter: RTL

Shares the single-port data RAM between the ARM core's data port and the camera capture stream. CPU accesses have fixed priority and pass straight through. Camera words are buffered in a small FIFO and written into a frame-buffer region of the RAM on idle RAM cycles. The CPU is stalled only when the FIFO is full. The block sits between the `arm` data port (ALUResult/WriteData/write_enable/ReadData) and the RAM `address_a/data_a/wren_a/q_a` port.

---
 rtl/arm_pkg.sv | 23 ++
 rtl/ram_port_arbiter_if.sv | 50 +++++
 rtl/sync_fifo.sv | 61 ++++++
 rtl/ram_port_arbiter.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// Shared types and default parameters for the CPU / camera RAM port arbiter.
package arm_pkg;

    localparam int unsigned DEF_ADDR_W      = 10;
    localparam int unsigned DEF_DATA_W      = 32;
    localparam int unsigned DEF_FIFO_DEPTH  = 8;
    localparam int unsigned DEF_FRAME_BASE  = 512;
    localparam int unsigned DEF_FRAME_WORDS = 256;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        FLUSH,
        DONE
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_CPU,
        GNT_CAM
    } arb_grant_t;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// CPU data port, camera stream, RAM port and status signals of the arbiter.
interface ram_port_arbiter_if
    import arm_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
);

    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_we;
    logic              cpu_re;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;

    logic              cam_frame_start;
    logic              cam_valid;
    logic [DATA_W-1:0] cam_data;
    logic              cam_ready;

    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_we;
    logic [DATA_W-1:0] ram_q;

    logic              frame_done;
    logic              cam_drop;
    logic              busy;

    // Arbiter side.
    modport slave (
        input  cpu_addr, cpu_wdata, cpu_we, cpu_re,
        input  cam_frame_start, cam_valid, cam_data,
        input  ram_q,
        output cpu_rdata, cpu_stall, cam_ready,
        output ram_addr, ram_wdata, ram_we,
        output frame_done, cam_drop, busy
    );

    // CPU, camera and RAM side.
    modport master (
        output cpu_addr, cpu_wdata, cpu_we, cpu_re,
        output cam_frame_start, cam_valid, cam_data,
        output ram_q,
        input  cpu_rdata, cpu_stall, cam_ready,
        input  ram_addr, ram_wdata, ram_we,
        input  frame_done, cam_drop, busy
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a push into a full FIFO is taken only alongside a pop.
module sync_fifo #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               push,
    input  logic                               pop,
    input  logic [DATA_W-1:0]                  din,
    output logic [DATA_W-1:0]                  dout,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    count,
    output logic                               full,
    output logic                               empty
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  cnt;
    logic              do_push;
    logic              do_pop;

    assign full    = (cnt == CNT_W'(FIFO_DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign dout    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one RAM port between the CPU data port (priority) and a buffered
// camera stream written into a frame-buffer region on idle RAM cycles.
module ram_port_arbiter
    import arm_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned FIFO_DEPTH  = DEF_FIFO_DEPTH,
    parameter int unsigned FRAME_BASE  = DEF_FRAME_BASE,
    parameter int unsigned FRAME_WORDS = DEF_FRAME_WORDS
) (
    input  logic              clk,
    input  logic              reset,
    ram_port_arbiter_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(FRAME_WORDS + 1);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    arb_state_t        state;
    arb_state_t        state_nxt;
    arb_grant_t        grant_c;

    logic [IDX_W-1:0]  acc_cnt;
    logic [IDX_W-1:0]  wr_idx;
    logic              cam_drop_q;

    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_dout;
    logic              push;
    logic              pop;
    logic              ready_c;
    logic              cpu_req;

    assign cpu_req = bus.cpu_we || bus.cpu_re;

    sync_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (push),
        .pop   (pop),
        .din   (bus.cam_data),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // State, frame counters and the sticky drop flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            acc_cnt    <= '0;
            wr_idx     <= '0;
            cam_drop_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && bus.cam_frame_start) begin
                acc_cnt <= '0;
                wr_idx  <= '0;
            end else begin
                if (push) begin
                    acc_cnt <= acc_cnt + IDX_W'(1);
                end
                if (pop && wr_idx != IDX_W'(FRAME_WORDS - 1)) begin
                    wr_idx <= wr_idx + IDX_W'(1);
                end
            end
            if (bus.cam_valid && !ready_c) begin
                cam_drop_q <= 1'b1;
            end
        end
    end

    // Grant mux, FIFO handshake and next state. RAM outputs are held at zero
    // while reset is asserted so the RAM sees no stray access.
    always_comb begin
        state_nxt     = state;
        grant_c       = GNT_NONE;
        pop           = 1'b0;
        push          = 1'b0;
        ready_c       = 1'b0;
        bus.cpu_stall = 1'b0;
        bus.cam_ready = 1'b0;
        bus.ram_addr  = '0;
        bus.ram_wdata = '0;
        bus.ram_we    = 1'b0;

        if (fifo_full) begin
            grant_c = GNT_CAM;
        end else if (cpu_req) begin
            grant_c = GNT_CPU;
        end else if (!fifo_empty) begin
            grant_c = GNT_CAM;
        end

        if (reset) begin
            case (grant_c)
                GNT_CPU: begin
                    bus.ram_addr  = bus.cpu_addr;
                    bus.ram_wdata = bus.cpu_wdata;
                    bus.ram_we    = bus.cpu_we;
                end
                GNT_CAM: begin
                    bus.ram_addr  = ADDR_W'(FRAME_BASE) + ADDR_W'(wr_idx);
                    bus.ram_wdata = fifo_dout;
                    bus.ram_we    = 1'b1;
                    bus.cpu_stall = cpu_req;
                    pop           = 1'b1;
                end
                default: begin
                    bus.ram_addr = bus.cpu_addr;
                end
            endcase

            ready_c       = (state == CAPTURE) &&
                            ((fifo_count < CNT_W'(FIFO_DEPTH)) || pop);
            push          = bus.cam_valid && ready_c;
            bus.cam_ready = ready_c;
        end

        case (state)
            IDLE: begin
                if (bus.cam_frame_start) begin
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                if (push && acc_cnt == IDX_W'(FRAME_WORDS - 1)) begin
                    state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                if (fifo_empty) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.cpu_rdata  = bus.ram_q;
    assign bus.frame_done = (state == DONE);
    assign bus.busy       = (state != IDLE);
    assign bus.cam_drop   = cam_drop_q;

endmodule
